reset_sequencer: RTL and testbench

Parametrised successor to the board reset conditioner: it accepts the raw asynchronous board reset, holds a configurable number of downstream reset channels asserted, and releases them one at a time in a fixed order. Each release is separated by a configurable gap. It also waits for an external clock-lock indication and supports a synchronous software re-reset. It sits at the top level between the reset button/PLL and every clocked subsystem in the `clk` domain (e.g. FIFO logic first, then USB/FT interface, then application).

---
 rtl/reset_seq_pkg.sv | 20 ++
 rtl/reset_sync.sv | 23 ++
 rtl/reset_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constant helpers for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        GAP       = 2'd2,
        DONE      = 2'd3
    } seq_state_t;

    // Larger of two integers, used to size the shared hold/gap counter.
    function automatic int max(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchroniser: asserts immediately, releases after STAGES clean edges.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_s
);

    logic [STAGES-1:0] sync_r;

    // Set the whole chain on reset, then shift zeros in to release it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], 1'b0};
        end
    end

    assign rst_s = sync_r[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds CHANNELS reset outputs until the clock is locked,
// then releases them one at a time, channel 0 first, GAP_CYCLES apart.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lock,
    input  logic                sw_req,
    output logic [CHANNELS-1:0] rst_out,
    output logic                ready
);

    localparam int CNT_W = $clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] ALL_ON    = {CHANNELS{1'b1}};

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("reset_sequencer: CHANNELS must be at least 1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("reset_sequencer: SYNC_STAGES must be at least 2");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("reset_sequencer: HOLD_CYCLES must be at least 1");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("reset_sequencer: GAP_CYCLES must be at least 1");
        end
    endgenerate

    logic                   rst_s;
    logic [SYNC_STAGES-1:0] lock_sync_r;
    logic                   lock_s;
    seq_state_t             state_r;
    seq_state_t             state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       idx_nxt_s;
    logic [CHANNELS-1:0]    rst_out_r;
    logic [CHANNELS-1:0]    rst_out_nxt_s;
    logic                   ready_r;
    logic                   ready_nxt_s;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk   (clk),
        .rst   (rst),
        .rst_s (rst_s)
    );

    // Lock synchroniser: cleared the instant reset asserts (the same moment
    // rst_s asserts) and refilled while rst_s is still releasing, so a lock
    // that is already stable is seen on the first edge the FSM runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = lock_sync_r[SYNC_STAGES-1];

    // State, counter, index and output registers, forced by the synchronised reset.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_r   <= WAIT_LOCK;
            cnt_r     <= {CNT_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            rst_out_r <= ALL_ON;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            idx_r     <= idx_nxt_s;
            rst_out_r <= rst_out_nxt_s;
            ready_r   <= ready_nxt_s;
        end
    end

    // Next-state selection; a lock drop outranks a software restart.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = WAIT_LOCK;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_nxt_s = WAIT_LOCK;
                end else if (sw_req) begin
                    state_nxt_s = HOLD;
                end else if (cnt_r == HOLD_LAST) begin
                    state_nxt_s = (CHANNELS == 1) ? DONE : GAP;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            GAP: begin
                if (!lock_s) begin
                    state_nxt_s = WAIT_LOCK;
                end else if (sw_req) begin
                    state_nxt_s = HOLD;
                end else if ((cnt_r == GAP_LAST) && (idx_r == IDX_LAST)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            DONE: begin
                if (!lock_s) begin
                    state_nxt_s = WAIT_LOCK;
                end else if (sw_req) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = WAIT_LOCK;
            end
        endcase
    end

    // Next counter, channel index and registered outputs; any override
    // reasserts every channel and restarts the count from zero.
    always_comb begin
        cnt_nxt_s     = {CNT_W{1'b0}};
        idx_nxt_s     = idx_r;
        rst_out_nxt_s = rst_out_r;
        ready_nxt_s   = ready_r;
        case (state_r)
            WAIT_LOCK: begin
                idx_nxt_s     = {IDX_W{1'b0}};
                rst_out_nxt_s = ALL_ON;
                ready_nxt_s   = 1'b0;
            end
            HOLD: begin
                if (!lock_s || sw_req) begin
                    idx_nxt_s     = {IDX_W{1'b0}};
                    rst_out_nxt_s = ALL_ON;
                    ready_nxt_s   = 1'b0;
                end else if (cnt_r == HOLD_LAST) begin
                    rst_out_nxt_s[0] = 1'b0;
                    idx_nxt_s        = IDX_W'(1);
                    ready_nxt_s      = (CHANNELS == 1) ? 1'b1 : 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            GAP: begin
                if (!lock_s || sw_req) begin
                    idx_nxt_s     = {IDX_W{1'b0}};
                    rst_out_nxt_s = ALL_ON;
                    ready_nxt_s   = 1'b0;
                end else if (cnt_r == GAP_LAST) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (idx_r == IDX_W'(i)) begin
                            rst_out_nxt_s[i] = 1'b0;
                        end else begin
                            rst_out_nxt_s[i] = rst_out_r[i];
                        end
                    end
                    if (idx_r == IDX_LAST) begin
                        ready_nxt_s = 1'b1;
                    end else begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            DONE: begin
                if (!lock_s || sw_req) begin
                    idx_nxt_s     = {IDX_W{1'b0}};
                    rst_out_nxt_s = ALL_ON;
                    ready_nxt_s   = 1'b0;
                end else begin
                    ready_nxt_s = 1'b1;
                end
            end
            default: begin
                idx_nxt_s     = {IDX_W{1'b0}};
                rst_out_nxt_s = ALL_ON;
                ready_nxt_s   = 1'b0;
            end
        endcase
    end

    assign rst_out = rst_out_r;
    assign ready   = ready_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance and a minimal-parameter
// instance share stimulus; a timeline model predicts both every edge and a
// monitor compares the DUTs against the queued predictions.
module tb_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       lock;
    logic       sw_req;
    logic [3:0] rst_out_a;
    logic       ready_a;
    logic [0:0] rst_out_b;
    logic       ready_b;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] a_out;
        logic       a_rdy;
        logic       b_out;
        logic       b_rdy;
    } exp_t;

    exp_t sb_q[$];

    // model state per instance: edges since rst low, lock history, running flag,
    // edges since the sequence (HOLD) started
    int m_rcnt [2] = '{0, 0};
    int m_pipe [2] = '{0, 0};
    bit m_act  [2] = '{1'b0, 1'b0};
    int m_k    [2] = '{0, 0};

    reset_sequencer u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .lock    (lock),
        .sw_req  (sw_req),
        .rst_out (rst_out_a),
        .ready   (ready_a)
    );

    reset_sequencer #(
        .CHANNELS    (1),
        .SYNC_STAGES (3),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (1)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .lock    (lock),
        .sw_req  (sw_req),
        .rst_out (rst_out_b),
        .ready   (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_sync(input int i); return (i == 0) ? 2 : 3; endfunction
    function automatic int cfg_hold(input int i); return (i == 0) ? 16 : 1; endfunction
    function automatic int cfg_gap(input int i);  return (i == 0) ? 8 : 1;  endfunction
    function automatic int cfg_ch(input int i);   return (i == 0) ? 4 : 1;  endfunction

    // channel c is released once the sequence has run hold + c*gap edges
    function automatic logic [3:0] exp_out(input int i, input bit act, input int k);
        logic [3:0] v;
        v = 4'b0000;
        for (int c = 0; c < cfg_ch(i); c++) begin
            v[c] = !(act && (k >= cfg_hold(i) + c * cfg_gap(i)));
        end
        return v;
    endfunction

    function automatic logic exp_rdy(input int i, input bit act, input int k);
        return act && (k >= cfg_hold(i) + (cfg_ch(i) - 1) * cfg_gap(i));
    endfunction

    // reference model: advance both timelines on each edge and queue predictions
    always @(posedge clk) begin
        exp_t e;
        logic [3:0] o;
        for (int i = 0; i < 2; i++) begin
            int rc;
            int pp;
            int kk;
            bit ac;
            bit run;
            bit ls;
            rc  = m_rcnt[i];
            pp  = m_pipe[i];
            kk  = m_k[i];
            ac  = m_act[i];
            run = !rst && (rc >= cfg_sync(i));
            ls  = ((pp >> (cfg_sync(i) - 1)) & 1) != 0;
            if (!run) begin
                ac = 1'b0;
                kk = 0;
            end else if (!ac) begin
                if (ls) begin
                    ac = 1'b1;
                    kk = 0;
                end
            end else if (!ls) begin
                ac = 1'b0;
                kk = 0;
            end else if (sw_req) begin
                kk = 0;
            end else if (kk < 100000) begin
                kk = kk + 1;
            end
            if (rst) begin
                rc = 0;
                pp = 0;
            end else begin
                if (rc < 100) rc = rc + 1;
                pp = ((pp << 1) | int'(lock)) & ((1 << cfg_sync(i)) - 1);
            end
            m_rcnt[i] <= rc;
            m_pipe[i] <= pp;
            m_k[i]    <= kk;
            m_act[i]  <= ac;
            o = exp_out(i, ac, kk);
            if (i == 0) begin
                e.a_out = o;
                e.a_rdy = exp_rdy(i, ac, kk);
            end else begin
                e.b_out = o[0];
                e.b_rdy = exp_rdy(i, ac, kk);
            end
        end
        sb_q.push_back(e);
    end

    // monitor: pop one prediction per edge and compare shortly after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if ({rst_out_a, ready_a} !== {e.a_out, e.a_rdy}) begin
                bad++;
                $display("FAIL seq_a t=%0t got rst_out=%b ready=%b want rst_out=%b ready=%b",
                         $time, rst_out_a, ready_a, e.a_out, e.a_rdy);
            end
            total++;
            if ({rst_out_b, ready_b} !== {e.b_out, e.b_rdy}) begin
                bad++;
                $display("FAIL seq_b t=%0t got rst_out=%b ready=%b want rst_out=%b ready=%b",
                         $time, rst_out_b, ready_b, e.b_out, e.b_rdy);
            end
        end
    end

    task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got {ready,rst_out}=%b want %b", nm, got, want);
        end
    endtask

    // advance one edge and land a few time units after it
    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    initial begin
        int rst_hold;
        rst    = 1'b1;
        lock   = 1'b1;
        sw_req = 1'b0;
        repeat (5) cyc();

        // power-up with defaults, edges counted from rst release
        rst = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            cyc();
            case (e)
                4:  chk("sweep_e4",  {3'b000, ready_b, rst_out_b}, 5'b00001);
                5:  chk("sweep_e5",  {3'b000, ready_b, rst_out_b}, 5'b00010);
                18: chk("pwr_e18",   {ready_a, rst_out_a}, 5'b01111);
                19: chk("pwr_e19",   {ready_a, rst_out_a}, 5'b01110);
                27: chk("pwr_e27",   {ready_a, rst_out_a}, 5'b01100);
                35: chk("pwr_e35",   {ready_a, rst_out_a}, 5'b01000);
                42: chk("pwr_e42",   {ready_a, rst_out_a}, 5'b01000);
                43: chk("pwr_e43",   {ready_a, rst_out_a}, 5'b10000);
                default: ;
            endcase
        end

        // software restart from DONE
        sw_req = 1'b1;
        cyc();
        sw_req = 1'b0;
        chk("sw_done_n", {ready_a, rst_out_a}, 5'b01111);
        for (int j = 1; j <= 25; j++) begin
            cyc();
            if (j == 15) chk("sw_done_15", {ready_a, rst_out_a}, 5'b01111);
            if (j == 16) chk("sw_done_16", {ready_a, rst_out_a}, 5'b01110);
            if (j == 24) chk("sw_done_24", {ready_a, rst_out_a}, 5'b01100);
        end

        // software restart mid-sequence at 1100
        sw_req = 1'b1;
        cyc();
        sw_req = 1'b0;
        chk("sw_mid", {ready_a, rst_out_a}, 5'b01111);
        for (int j = 1; j <= 20; j++) begin
            cyc();
            if (j == 16) chk("sw_mid_16", {ready_a, rst_out_a}, 5'b01110);
        end

        // asynchronous reset in the middle of a gap, between edges
        rst = 1'b1;
        #1;
        chk("async_rst_a", {ready_a, rst_out_a}, 5'b01111);
        chk("async_rst_b", {3'b000, ready_b, rst_out_b}, 5'b00001);
        repeat (4) cyc();

        // lock gating, with ignored software requests while waiting
        lock = 1'b0;
        rst  = 1'b0;
        for (int j = 1; j <= 100; j++) begin
            sw_req = ((j % 30) == 0);
            cyc();
        end
        sw_req = 1'b0;
        chk("lock_gate", {ready_a, rst_out_a}, 5'b01111);
        lock = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            cyc();
            if (e == 18) chk("lock_rise_18", {ready_a, rst_out_a}, 5'b01111);
            if (e == 19) chk("lock_rise_19", {ready_a, rst_out_a}, 5'b01110);
        end
        repeat (40) cyc();

        // lock drop and software request seen in the same cycle
        lock = 1'b0;
        cyc();
        cyc();
        sw_req = 1'b1;
        cyc();
        sw_req = 1'b0;
        chk("lock_sw", {ready_a, rst_out_a}, 5'b01111);
        lock = 1'b1;
        repeat (30) cyc();

        // randomized mix of restarts, lock drops and resets
        rst_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            sw_req = ($urandom_range(0, 24) == 0);
            if (rst_hold > 0) begin
                rst_hold = rst_hold - 1;
                if (rst_hold == 0) rst = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                rst      = 1'b1;
                rst_hold = int'($urandom_range(2, 5));
            end
            if (lock == 1'b0) begin
                if ($urandom_range(0, 7) == 0) lock = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                lock = 1'b0;
            end
            cyc();
        end
        sw_req = 1'b0;
        rst    = 1'b0;
        lock   = 1'b1;
        repeat (60) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
